ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 117 +++++++++++
 tb/tb_ex_muldiv_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit stalling the pipeline while it works
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_in,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic [6:0]      funct7_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [4:0]      rd_in,
  output logic            stall_out,
  output logic            result_valid_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out,
  output logic            busy_out
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  logic [1:0] state_q, state_d;
  logic [4:0] count_q, count_d, rd_q, rd_d;
  logic [2:0] f3_q, f3_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;
  logic negq_q, negq_d, negr_q, negr_d;
  logic start, sa, sb, neg_a, neg_b, div_zero, ovf, div_ok;
  logic [XLEN-1:0] mag_a, mag_b, it_hi, it_lo, quo, rem, fin;
  logic [XLEN:0] mul_sum, div_sh;
  logic [2*XLEN-1:0] prod;
  always_comb begin
    start = state_q == IDLE && opcode_in == 7'b0110011 && funct7_in == 7'b0000001 && !flush_in && !reset;
    sa = funct3_in[2] ? !funct3_in[0] : funct3_in[1:0] != 2'd3;
    sb = funct3_in[2] ? !funct3_in[0] : !funct3_in[1];
    neg_a = sa && rs1_data_in[XLEN-1];
    neg_b = sb && rs2_data_in[XLEN-1];
    mag_a = neg_a ? -rs1_data_in : rs1_data_in;
    mag_b = neg_b ? -rs2_data_in : rs2_data_in;
    div_zero = funct3_in[2] && rs2_data_in == '0;
    ovf = funct3_in[2] && !funct3_in[0] && rs1_data_in == SMIN && rs2_data_in == '1;
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh = {hi_q, lo_q[XLEN-1]};
    div_ok = div_sh >= {1'b0, b_q};
    it_hi = f3_q[2] ? (div_ok ? div_sh[XLEN-1:0] - b_q : div_sh[XLEN-1:0]) : mul_sum[XLEN:1];
    it_lo = f3_q[2] ? {lo_q[XLEN-2:0], div_ok} : {mul_sum[0], lo_q[XLEN-1:1]};
    prod = negq_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    quo = negq_q ? -it_lo : it_lo;
    rem = negr_q ? -it_hi : it_hi;
    fin = f3_q[2] ? (f3_q[1] ? rem : quo) : (f3_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d = rd_q;
    f3_d = f3_q;
    hi_d = hi_q;
    lo_d = lo_q;
    b_d = b_q;
    negq_d = negq_q;
    negr_d = negr_q;
    result_d = result_q;
    if (start) begin
      state_d = div_zero || ovf ? DONE : CALC;
      count_d = '0;
      rd_d = rd_in;
      f3_d = funct3_in;
      hi_d = '0;
      lo_d = mag_a;
      b_d = mag_b;
      negq_d = neg_a ^ neg_b;
      negr_d = neg_a;
      result_d = div_zero ? (funct3_in[1] ? rs1_data_in : '1) : ovf ? (funct3_in[1] ? '0 : SMIN) : result_q;
    end else if (state_q == CALC && flush_in) begin
      state_d = IDLE;
    end else if (state_q == CALC) begin
      hi_d = it_hi;
      lo_d = it_lo;
      count_d = count_q + 5'd1;
      state_d = count_q == 5'd31 ? DONE : CALC;
      result_d = count_q == 5'd31 ? fin : result_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rd_q <= '0;
      f3_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      b_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q <= rd_d;
      f3_q <= f3_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q <= b_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      result_q <= result_d;
    end
  end
  always_comb begin
    stall_out = start || state_q == CALC;
    result_valid_out = state_q == DONE && !flush_in;
    busy_out = state_q != IDLE;
    result_out = result_q;
    rd_out = rd_q;
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit against an arithmetic reference model
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic reset, flush_in;
  logic [6:0] opcode_in, funct7_in;
  logic [2:0] funct3_in;
  logic [31:0] rs1_data_in, rs2_data_in, result_out;
  logic [4:0] rd_in, rd_out;
  logic stall_out, result_valid_out, busy_out;
  int tests = 0;
  int fails = 0;
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [5:0]  lat;
  } exp_t;
  exp_t q[$];
  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush_in(flush_in),
    .opcode_in(opcode_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .rd_in(rd_in),
    .stall_out(stall_out), .result_valid_out(result_valid_out),
    .result_out(result_out), .rd_out(rd_out), .busy_out(busy_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (f)
      3'd0, 3'd3: p = {32'b0, a} * {32'b0, b};
      3'd1: p = 64'(sa * sb);
      3'd2: p = 64'(sa * longint'({32'b0, b}));
      default: p = '0;
    endcase
    if (!f[2]) return f == 3'd0 ? p[31:0] : p[63:32];
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    case (f)
      3'd4: return 32'(sa / sb);
      3'd5: return a / b;
      3'd6: return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction
  function automatic logic [5:0] lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 6'd1 : 6'd33;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask
  task automatic nop();
    opcode_in = 7'b0010011;
    funct7_in = 7'd0;
    funct3_in = 3'd0;
    rs1_data_in = $urandom;
    rs2_data_in = $urandom;
    rd_in = 5'($urandom);
  endtask
  task automatic mop(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    opcode_in = 7'b0110011;
    funct7_in = 7'b0000001;
    funct3_in = f;
    rs1_data_in = a;
    rs2_data_in = b;
    rd_in = rd;
  endtask
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expv);
    logic seen;
    int n;
    q.push_back('{expv, rd, lat_of(f, a, b)});
    mop(f, a, b, rd);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      seen = result_valid_out;
      n++;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL op_timeout: funct3=%0d no result_valid_out within %0d cycles", f, n);
    end
    @(posedge clk);
    #1;
    nop();
  endtask
  initial begin
    int sc;
    logic pv;
    exp_t e;
    sc = 0;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid_out) begin
        chk("valid_single_cycle", {31'b0, pv}, 32'd0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %h rd %0d expected none", result_out, rd_out);
        end else begin
          e = q.pop_front();
          chk("result", result_out, e.res);
          chk("rd", {27'b0, rd_out}, {27'b0, e.rd});
          chk("stall_cycles", 32'(sc), {26'b0, e.lat});
        end
        sc = 0;
      end else if (stall_out) begin
        sc++;
      end else begin
        sc = 0;
      end
      pv = result_valid_out;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    logic [2:0] f;
    logic [31:0] a, b;
    reset = 1'b1;
    flush_in = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", result_out, 32'd0);
    chk("reset_rd", {27'b0, rd_out}, 32'd0);
    chk("reset_valid", {31'b0, result_valid_out}, 32'd0);
    chk("reset_busy", {31'b0, busy_out}, 32'd0);
    chk("reset_stall", {31'b0, stall_out}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_op(3'd0, 32'd7, 32'd6, 5'd5, 32'h0000_002A);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd4, 32'hFFFF_FFFA);
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6, 32'hFFFF_FFFE);
    run_op(3'd5, 32'd20, 32'd3, 5'd7, 32'd6);
    run_op(3'd7, 32'd20, 32'd3, 5'd8, 32'd2);
    run_op(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5, 32'd0, 5'd10, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    mop(3'd0, 32'd123, 32'd456, 5'd12);
    repeat (11) @(posedge clk);
    #1;
    flush_in = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", {31'b0, busy_out}, 32'd1);
    chk("flush_valid", {31'b0, result_valid_out}, 32'd0);
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    nop();
    @(negedge clk);
    chk("flush_busy_after", {31'b0, busy_out}, 32'd0);
    chk("flush_stall_after", {31'b0, stall_out}, 32'd0);
    chk("flush_valid_after", {31'b0, result_valid_out}, 32'd0);
    mop(3'd5, 32'd1000, 32'd7, 5'd13);
    repeat (21) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    nop();
    @(negedge clk);
    chk("rst_mid_result", result_out, 32'd0);
    chk("rst_mid_rd", {27'b0, rd_out}, 32'd0);
    chk("rst_mid_valid", {31'b0, result_valid_out}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy_out}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall_out}, 32'd0);
    @(posedge clk);
    #1;
    opcode_in = 7'b0110011;
    funct7_in = 7'd0;
    funct3_in = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("add_stall", {31'b0, stall_out}, 32'd0);
      chk("add_busy", {31'b0, busy_out}, 32'd0);
    end
    @(posedge clk);
    #1;
    nop();
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      else if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      run_op(f, a, b, 5'($urandom_range(0, 31)), model(f, a, b));
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
